load_store_unit: RTL and testbench

Memory-stage responder for the RV32I pipeline: consumes the MemRead/MemWrite/func3 controls issued by the control unit, runs a req/ack transaction on the data-memory bus, and returns aligned, sign- or zero-extended load data. It stalls the pipeline while an access is outstanding. Misaligned, illegal or timed-out accesses raise a one-cycle fault with no bus side effects.

---
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Request side is registered in the master; rdata is only meaningful while ack is high.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I MEM-stage load/store responder: 3+ cycles per access (request, BUSY until ack, DONE).
// Backpressure: stall holds the pipeline from acceptance through the ack cycle; timeout aborts.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state, w_next;
    logic        r_req, r_we, r_tmo;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic [15:0] r_cnt;
    logic [2:0]  r_f3;
    logic [1:0]  r_lane;

    logic        w_req, w_ld_ok, w_st_ok, w_misal, w_illegal, w_tmo_hit;
    logic [3:0]  w_be;
    logic [31:0] w_wd, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_req     = MemRead | MemWrite;
    assign w_st_ok   = !func3[2] && (func3[1:0] != 2'b11);
    assign w_misal   = ((func3[1:0] == 2'b01) && addr[0]) ||
                       ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign w_illegal = w_req && ((MemRead && MemWrite) || (MemRead && !w_ld_ok) ||
                                 (MemWrite && !w_st_ok) || w_misal);
    assign w_tmo_hit = (r_cnt == 16'(TIMEOUT - 1));

    always_comb begin
        case (func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ld_ok = 1'b1;
            default:                                w_ld_ok = 1'b0;
        endcase
    end

    // Store lanes: enables and replicated data; loads always fetch the whole word.
    always_comb begin
        w_be = 4'b1111;
        w_wd = wdata;
        if (MemWrite) begin
            case (func3[1:0])
                2'b00: begin
                    w_be = 4'b0001 << addr[1:0];
                    w_wd = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_be = 4'b0011 << {addr[1], 1'b0};
                    w_wd = {2{wdata[15:0]}};
                end
                default: begin
                    w_be = 4'b1111;
                    w_wd = wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (r_lane)
            2'b00:   w_byte = bus.bus_rdata[7:0];
            2'b01:   w_byte = bus.bus_rdata[15:8];
            2'b10:   w_byte = bus.bus_rdata[23:16];
            default: w_byte = bus.bus_rdata[31:24];
        endcase
        w_half = r_lane[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'b0, w_byte};
            3'b101:  w_ext = {16'b0, w_half};
            default: w_ext = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        fault  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_illegal) begin
                    fault = 1'b1;
                end else if (w_req) begin
                    stall  = 1'b1;
                    w_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.bus_ack || w_tmo_hit) w_next = DONE;
            end
            DONE: begin
                fault  = r_tmo;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_f3    <= '0;
            r_lane  <= '0;
            r_tmo   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !w_illegal) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite;
                        r_addr  <= {addr[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wd;
                        r_f3    <= func3;
                        r_lane  <= addr[1:0];
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    // A late ack on the final cycle still wins over the timeout.
                    if (bus.bus_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) r_rdata <= w_ext;
                    end else if (w_tmo_hit) begin
                        r_req <= 1'b0;
                        r_tmo <= 1'b1;
                        if (!r_we) r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DONE:    r_tmo <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rdata         = r_rdata;
    assign bus.bus_req   = r_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level reference model.
module tb_load_store_unit;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  func3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, fault;
    logic [31:0] m_rdata;
    int          n_checks = 0;
    int          n_err    = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .func3    (func3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .fault    (fault),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit is_legal(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] a);
        if (rd && wr) return 1'b0;
        if (rd && !(f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if (wr && !(f inside {3'b000, 3'b001, 3'b010})) return 1'b0;
        if ((a % size_of(f)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_be(input bit wr, input logic [2:0] f, input logic [31:0] a);
        logic [3:0] be = 4'b0;
        int lo = int'(a % 4);
        if (!wr) return 4'b1111;
        for (int i = 0; i < 4; i++)
            if (i >= lo && i < lo + size_of(f)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input bit wr, input logic [2:0] f, input logic [31:0] w);
        logic [31:0] r = '0;
        if (!wr) return w;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % size_of(f)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int sz = size_of(f);
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*sz)) - 32'h1);
        logic [31:0] v = (d >> (8*(a % 4))) & mask;
        if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One MEM-stage access; ack_at is the BUSY cycle carrying ack (0 or > TO means it never arrives in time).
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] brd, input int ack_at,
                             input bit dchk, input logic [3:0] dbe, input logic [31:0] dwd);
        bit legal = is_legal(rd, wr, f, a);
        bit timed = !(ack_at >= 1 && ack_at <= int'(TO));
        int done  = timed ? int'(TO) + 1 : ack_at + 1;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; func3 = f; addr = a; wdata = wd;
        bus.bus_ack = 1'b0; bus.bus_rdata = $urandom;
        @(negedge clk);
        if (!legal) begin
            chk("ill_fault", fault, 1);
            chk("ill_stall", stall, 0);
            chk("ill_req", bus.bus_req, 0);
            @(posedge clk); #1;
            MemRead = 1'b0; MemWrite = 1'b0;
            @(negedge clk);
            chk("ill_req_next", bus.bus_req, 0);
            chk("ill_fault_next", fault, 0);
            chk("ill_rdata", rdata, m_rdata);
            return;
        end
        chk("acc_stall0", stall, 1);
        chk("acc_fault0", fault, 0);
        for (int c = 1; c <= done; c++) begin
            @(posedge clk); #1;
            bus.bus_ack   = (c == ack_at) || (c == done && $urandom_range(0, 1) == 1);
            bus.bus_rdata = (c == ack_at) ? brd : $urandom;
            @(negedge clk);
            if (c < done) begin
                chk("busy_stall", stall, 1);
                chk("busy_fault", fault, 0);
                chk("busy_req", bus.bus_req, 1);
                chk("busy_we", bus.bus_we, wr);
                chk("busy_addr", bus.bus_addr, {a[31:2], 2'b00});
                chk("busy_be", bus.bus_be, m_be(wr, f, a));
                chk("busy_wdata", bus.bus_wdata, m_wd(wr, f, wd));
                if (dchk && c == 1) begin
                    chk("dir_be", bus.bus_be, dbe);
                    chk("dir_wdata", bus.bus_wdata, dwd);
                end
            end else begin
                if (rd) m_rdata = timed ? 32'h0 : m_load(f, a, brd);
                chk("done_stall", stall, 0);
                chk("done_req", bus.bus_req, 0);
                chk("done_fault", fault, timed);
                chk("done_rdata", rdata, m_rdata);
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; bus.bus_ack = $urandom_range(0, 1);
        @(negedge clk);
        chk("idle_stall", stall, 0);
        chk("idle_fault", fault, 0);
        chk("idle_req", bus.bus_req, 0);
        chk("idle_rdata", rdata, m_rdata);
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; func3 = '0; addr = '0; wdata = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_req", bus.bus_req, 0);
        chk("rst_we", bus.bus_we, 0);
        chk("rst_addr", bus.bus_addr, 0);
        chk("rst_be", bus.bus_be, 0);
        chk("rst_wdata", bus.bus_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fault", fault, 0);

        do_access(1, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 1, 1, 4'b1111, 32'h0);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        do_access(1, 0, 3'b000, 32'h103, 0, 32'h80FF_1234, 2, 0, 4'b0, 32'h0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        do_access(1, 0, 3'b100, 32'h103, 0, 32'h80FF_1234, 1, 0, 4'b0, 32'h0);
        chk("lbu_rdata", rdata, 32'h0000_0080);
        do_access(1, 0, 3'b001, 32'h102, 0, 32'h80FF_1234, 3, 0, 4'b0, 32'h0);
        chk("lh_rdata", rdata, 32'hFFFF_80FF);
        do_access(0, 1, 3'b000, 32'h21, 32'h0000_00A5, 0, 1, 1, 4'b0010, 32'hA5A5_A5A5);
        chk("sb_keeps_rdata", rdata, 32'hFFFF_80FF);
        do_access(0, 1, 3'b001, 32'h22, 32'h0000_1234, 0, 2, 1, 4'b1100, 32'h1234_1234);
        do_access(1, 0, 3'b010, 32'h102, 0, 0, 1, 0, 4'b0, 32'h0);
        do_access(1, 1, 3'b010, 32'h100, 0, 0, 1, 0, 4'b0, 32'h0);
        do_access(1, 0, 3'b011, 32'h100, 0, 0, 1, 0, 4'b0, 32'h0);
        chk("ill_keeps_rdata", rdata, 32'hFFFF_80FF);
        do_access(1, 0, 3'b010, 32'h200, 0, 32'h1111_2222, int'(TO), 0, 4'b0, 32'h0);
        do_access(1, 0, 3'b010, 32'h300, 0, 32'h5555_AAAA, 0, 0, 4'b0, 32'h0);
        chk("tmo_rdata", rdata, 32'h0);
        idle_cycle();

        // Reset while BUSY, ack arriving the cycle after.
        do_access(1, 0, 3'b010, 32'h40, 0, 32'h0BAD_F00D, 1, 0, 4'b0, 32'h0);
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010; addr = 32'h80; bus.bus_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; MemRead = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'h1234_5678;
        m_rdata = '0;
        @(negedge clk);
        chk("mid_rst_req", bus.bus_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_rdata", rdata, 0);
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        chk("mid_rst_req2", bus.bus_req, 0);
        chk("mid_rst_rdata2", rdata, 0);
        chk("mid_rst_fault", fault, 0);

        for (int n = 0; n < 300; n++) begin
            int sel = $urandom_range(0, 9);
            bit rd  = (sel <= 5) || (sel == 9);
            bit wr  = (sel >= 6);
            logic [2:0]  f  = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            int          ak = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, int'(TO) + 1);
            if ($urandom_range(0, 3) != 0 && !rd) f = 3'($urandom_range(0, 2));
            do_access(rd, wr, f, a, $urandom, $urandom, ak, 0, 4'b0, 32'h0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
